// File: rtl/intc_pkg.sv
// intc_pkg: shared constants and types for the intr_ctrl01 interrupt controller.
// The optional Timer 2 source is enabled by defining the macro INTC_TIMR2_EN.
package intc_pkg;

    // Default SFR direct addresses
    localparam logic [7:0] IE_ADDR = 8'hA8;
    localparam logic [7:0] IP_ADDR = 8'hB8;

`ifdef INTC_TIMR2_EN
    localparam int NUM_SRC = 6;
`else
    localparam int NUM_SRC = 5;
`endif

    // Writable bits: EA plus one enable/priority bit per source
    localparam logic [7:0] IE_WMASK = 8'h80 | 8'((1 << NUM_SRC) - 1);
    localparam logic [7:0] IP_WMASK = 8'((1 << NUM_SRC) - 1);

    // Vector addresses per source
    localparam logic [15:0] VEC_EX0 = 16'h0003;
    localparam logic [15:0] VEC_ET0 = 16'h000B;
    localparam logic [15:0] VEC_EX1 = 16'h0013;
    localparam logic [15:0] VEC_ET1 = 16'h001B;
    localparam logic [15:0] VEC_ES  = 16'h0023;
`ifdef INTC_TIMR2_EN
    localparam logic [15:0] VEC_T2  = 16'h002B;
`endif

    // Source index doubles as the IE/IP bit position and the fixed
    // in-level priority (lower index wins)
    typedef enum logic [2:0] {
        SRC_EX0 = 3'd0,
        SRC_ET0 = 3'd1,
        SRC_EX1 = 3'd2,
        SRC_ET1 = 3'd3,
        SRC_ES  = 3'd4
`ifdef INTC_TIMR2_EN
        , SRC_T2 = 3'd5
`endif
    } src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    // Map a source index to its vector address
    function automatic logic [15:0] vector_of(input logic [2:0] src);
        logic [15:0] v;
        case (src)
            SRC_EX0: v = VEC_EX0;
            SRC_ET0: v = VEC_ET0;
            SRC_EX1: v = VEC_EX1;
            SRC_ET1: v = VEC_ET1;
            SRC_ES:  v = VEC_ES;
`ifdef INTC_TIMR2_EN
            SRC_T2:  v = VEC_T2;
`endif
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Index of the lowest set bit, i.e. the highest fixed-priority source
    function automatic logic [2:0] first_set(input logic [NUM_SRC-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_prio_resolver.sv
// intr_prio_resolver: combinational two-level priority resolution with nesting.
// Picks the winning eligible source, honouring which level is currently in service.
module intr_prio_resolver
    import intc_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] enable,
    input  logic               ea,
    input  logic [NUM_SRC-1:0] prio,
    input  logic               in_service_hi,
    input  logic               in_service_lo,
    output logic [NUM_SRC-1:0] eligible,
    output logic               valid,
    output logic [2:0]         src,
    output logic               level
);

    logic [NUM_SRC-1:0] hi_cand;
    logic [NUM_SRC-1:0] lo_cand;

    // Qualify raw requests by their enables and split them by priority level
    always_comb begin
        eligible = req & enable & {NUM_SRC{ea}};
        hi_cand  = eligible & prio;
        lo_cand  = eligible & ~prio;
    end

    // High level wins first; a LO in service lets only HI through, a HI in service blocks all
    always_comb begin
        valid = 1'b0;
        src   = 3'd0;
        level = 1'b0;
        if (!in_service_hi) begin
            if (|hi_cand) begin
                valid = 1'b1;
                level = 1'b1;
                src   = first_set(hi_cand);
            end else if (!in_service_lo && (|lo_cand)) begin
                valid = 1'b1;
                level = 1'b0;
                src   = first_set(lo_cand);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl01.sv
// intr_ctrl01: 8051-style interrupt controller. Owns IE/IP SFRs, tracks nested
// in-service levels, and presents a single vectored request to the core.
// Define INTC_TIMR2_EN to add the Timer 2 source (TIMR2_INT_REQ / IACK_TIMR2).
module intr_ctrl01
    import intc_pkg::*;
#(
    parameter logic [7:0] IE_ADDRESS = IE_ADDR,
    parameter logic [7:0] IP_ADDRESS = IP_ADDR
)(
    input  logic        CPUClock,
    input  logic        RESET,
    input  logic [7:0]  DIR_RD_ADDRS,
    input  logic [7:0]  DIR_WR_ADDRS,
    input  logic [7:0]  WR_DATA,
    output logic [7:0]  RD_DATA,
    input  logic        DIRECT_WR,
    input  logic        WR_EN,
    input  logic        EXT0_INT_REQ,
    input  logic        TIMR0_INT_REQ,
    input  logic        EXT1_INT_REQ,
    input  logic        TIMR1_INT_REQ,
    input  logic        SER_INT_REQ,
`ifdef INTC_TIMR2_EN
    input  logic        TIMR2_INT_REQ,
    output logic        IACK_TIMR2,
`endif
    input  logic        INT_ACK,
    input  logic        RETI_EXEC,
    output logic        INT_REQ,
    output logic [15:0] INT_VECTOR,
    output logic        IACK_EXT0,
    output logic        IACK_TIMR0,
    output logic        IACK_EXT1,
    output logic        IACK_TIMR1
);

    logic [7:0]         ie_reg;
    logic [7:0]         ip_reg;
    logic               sfr_wr;

    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] eligible;
    logic               win_valid;
    logic [2:0]         win_src;
    logic               win_level;

    state_e             state;
    logic [2:0]         lat_src;
    logic               lat_level;
    logic [NUM_SRC-1:0] lat_mask;
    logic               lat_still_elig;
    logic               take_ack;

    logic               in_service_hi;
    logic               in_service_lo;
    logic               svc_hi_next;
    logic               svc_lo_next;

    logic [3:0]         iack_q;
`ifdef INTC_TIMR2_EN
    logic               iack_t2_q;
`endif

`ifdef INTC_TIMR2_EN
    assign req_vec = {TIMR2_INT_REQ, SER_INT_REQ, TIMR1_INT_REQ,
                      EXT1_INT_REQ, TIMR0_INT_REQ, EXT0_INT_REQ};
`else
    assign req_vec = {SER_INT_REQ, TIMR1_INT_REQ,
                      EXT1_INT_REQ, TIMR0_INT_REQ, EXT0_INT_REQ};
`endif

    assign sfr_wr         = WR_EN & DIRECT_WR;
    assign lat_mask       = NUM_SRC'(1) << lat_src;
    assign lat_still_elig = |(eligible & lat_mask);
    assign take_ack       = (state == ST_PEND) & INT_ACK;

    // IE/IP registers; unimplemented bits are forced to zero on write
    always_ff @(posedge CPUClock) begin
        if (RESET) begin
            ie_reg <= 8'h00;
            ip_reg <= 8'h00;
        end else if (sfr_wr) begin
            if (DIR_WR_ADDRS == IE_ADDRESS) ie_reg <= WR_DATA & IE_WMASK;
            if (DIR_WR_ADDRS == IP_ADDRESS) ip_reg <= WR_DATA & IP_WMASK;
        end
    end

    // Combinational SFR read mux
    always_comb begin
        RD_DATA = 8'h00;
        if (DIR_RD_ADDRS == IE_ADDRESS) begin
            RD_DATA = ie_reg;
        end else if (DIR_RD_ADDRS == IP_ADDRESS) begin
            RD_DATA = ip_reg;
        end
    end

    intr_prio_resolver u_resolver (
        .req           (req_vec),
        .enable        (ie_reg[NUM_SRC-1:0]),
        .ea            (ie_reg[7]),
        .prio          (ip_reg[NUM_SRC-1:0]),
        .in_service_hi (in_service_hi),
        .in_service_lo (in_service_lo),
        .eligible      (eligible),
        .valid         (win_valid),
        .src           (win_src),
        .level         (win_level)
    );

    // Request FSM: latch the winner in IDLE, hold it frozen in PEND until acked or withdrawn
    always_ff @(posedge CPUClock) begin
        if (RESET) begin
            state      <= ST_IDLE;
            INT_REQ    <= 1'b0;
            INT_VECTOR <= 16'h0000;
            lat_src    <= 3'd0;
            lat_level  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state      <= ST_PEND;
                        INT_REQ    <= 1'b1;
                        INT_VECTOR <= vector_of(win_src);
                        lat_src    <= win_src;
                        lat_level  <= win_level;
                    end
                end
                ST_PEND: begin
                    if (INT_ACK || !lat_still_elig) begin
                        state   <= ST_IDLE;
                        INT_REQ <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    INT_REQ <= 1'b0;
                end
            endcase
        end
    end

    // Next in-service flags: RETI retires the innermost level before a same-cycle ack marks the new one
    always_comb begin
        svc_hi_next = in_service_hi;
        svc_lo_next = in_service_lo;
        if (RETI_EXEC) begin
            if (in_service_hi) svc_hi_next = 1'b0;
            else               svc_lo_next = 1'b0;
        end
        if (take_ack) begin
            if (lat_level) svc_hi_next = 1'b1;
            else           svc_lo_next = 1'b1;
        end
    end

    // In-service level registers
    always_ff @(posedge CPUClock) begin
        if (RESET) begin
            in_service_hi <= 1'b0;
            in_service_lo <= 1'b0;
        end else begin
            in_service_hi <= svc_hi_next;
            in_service_lo <= svc_lo_next;
        end
    end

    // One-cycle flag-clear pulses; the serial flags are left for software to clear
    always_ff @(posedge CPUClock) begin
        if (RESET) begin
            iack_q <= 4'b0000;
        end else begin
            iack_q[0] <= take_ack && (lat_src == SRC_EX0);
            iack_q[1] <= take_ack && (lat_src == SRC_ET0);
            iack_q[2] <= take_ack && (lat_src == SRC_EX1);
            iack_q[3] <= take_ack && (lat_src == SRC_ET1);
        end
    end

`ifdef INTC_TIMR2_EN
    // Timer 2 flag-clear pulse
    always_ff @(posedge CPUClock) begin
        if (RESET) iack_t2_q <= 1'b0;
        else       iack_t2_q <= take_ack && (lat_src == SRC_T2);
    end

    assign IACK_TIMR2 = iack_t2_q;
`endif

    assign IACK_EXT0  = iack_q[0];
    assign IACK_TIMR0 = iack_q[1];
    assign IACK_EXT1  = iack_q[2];
    assign IACK_TIMR1 = iack_q[3];

endmodule

// File: tb/tb_intr_ctrl01.sv
// tb_intr_ctrl01: directed scenarios plus a randomized run checked against a
// queue-based behavioural model of the interrupt controller.
module tb_intr_ctrl01;

`ifdef INTC_TIMR2_EN
    localparam int NS = 6;
`else
    localparam int NS = 5;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rd_addr = 8'h00;
    logic [7:0]  wr_addr = 8'h00;
    logic [7:0]  wr_data = 8'h00;
    logic [7:0]  rd_data;
    logic        direct_wr = 1'b0;
    logic        wr_en = 1'b0;
    logic        ext0 = 1'b0, timr0 = 1'b0, ext1 = 1'b0, timr1 = 1'b0, ser = 1'b0;
`ifdef INTC_TIMR2_EN
    logic        timr2 = 1'b0;
    logic        iack_timr2;
`endif
    logic        int_ack = 1'b0;
    logic        reti = 1'b0;
    logic        int_req;
    logic [15:0] int_vector;
    logic        iack_ext0, iack_timr0, iack_ext1, iack_timr1;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state; in-service levels kept as a nesting stack
    logic [7:0]  m_ie = 8'h00;
    logic [7:0]  m_ip = 8'h00;
    logic        m_pend = 1'b0;
    int          m_src = 0;
    logic        m_lvl = 1'b0;
    logic [15:0] m_vec = 16'h0000;
    logic [5:0]  m_iack = 6'b0;
    logic        m_svc[$];

    always #5 clk = ~clk;

    intr_ctrl01 dut (
        .CPUClock      (clk),
        .RESET         (reset),
        .DIR_RD_ADDRS  (rd_addr),
        .DIR_WR_ADDRS  (wr_addr),
        .WR_DATA       (wr_data),
        .RD_DATA       (rd_data),
        .DIRECT_WR     (direct_wr),
        .WR_EN         (wr_en),
        .EXT0_INT_REQ  (ext0),
        .TIMR0_INT_REQ (timr0),
        .EXT1_INT_REQ  (ext1),
        .TIMR1_INT_REQ (timr1),
        .SER_INT_REQ   (ser),
`ifdef INTC_TIMR2_EN
        .TIMR2_INT_REQ (timr2),
        .IACK_TIMR2    (iack_timr2),
`endif
        .INT_ACK       (int_ack),
        .RETI_EXEC     (reti),
        .INT_REQ       (int_req),
        .INT_VECTOR    (int_vector),
        .IACK_EXT0     (iack_ext0),
        .IACK_TIMR0    (iack_timr0),
        .IACK_EXT1     (iack_ext1),
        .IACK_TIMR1    (iack_timr1)
    );

    function automatic logic [NS-1:0] cur_reqs();
        logic [NS-1:0] r;
        r = '0;
        r[0] = ext0; r[1] = timr0; r[2] = ext1; r[3] = timr1; r[4] = ser;
`ifdef INTC_TIMR2_EN
        r[5] = timr2;
`endif
        return r;
    endfunction

    function automatic logic [5:0] dut_iacks();
        logic [5:0] v;
        v = {2'b00, iack_timr1, iack_ext1, iack_timr0, iack_ext0};
`ifdef INTC_TIMR2_EN
        v[5] = iack_timr2;
`endif
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [NS-1:0] r;
        logic [7:0]    nie, nip;
        int            depth, best;
        logic          top, blvl;
        r = cur_reqs();
        m_iack = 6'b0;
        if (reset) begin
            m_ie = 8'h00; m_ip = 8'h00; m_pend = 1'b0; m_src = 0; m_lvl = 1'b0;
            m_vec = 16'h0000; m_svc.delete();
            return;
        end
        nie = m_ie; nip = m_ip;
        if (wr_en && direct_wr && wr_addr == 8'hA8) nie = wr_data & (8'h80 | 8'((1 << NS) - 1));
        if (wr_en && direct_wr && wr_addr == 8'hB8) nip = wr_data & 8'((1 << NS) - 1);
        depth = m_svc.size();
        top = (depth > 0) ? m_svc[depth-1] : 1'b0;
        if (reti && depth > 0) void'(m_svc.pop_back());
        if (m_pend) begin
            if (int_ack) begin
                m_svc.push_back(m_lvl);
                if (m_src != 4) m_iack[m_src] = 1'b1;
                m_pend = 1'b0;
            end else if (!(r[m_src] && m_ie[m_src] && m_ie[7])) begin
                m_pend = 1'b0;
            end
        end else begin
            best = -1; blvl = 1'b0;
            for (int lvl = 1; lvl >= 0; lvl--) begin
                if (best < 0 && (depth == 0 || (top == 1'b0 && lvl == 1))) begin
                    for (int s = NS - 1; s >= 0; s--) begin
                        if (r[s] && m_ie[s] && m_ie[7] && m_ip[s] == lvl[0]) begin
                            best = s; blvl = lvl[0];
                        end
                    end
                end
            end
            if (best >= 0) begin
                m_pend = 1'b1; m_src = best; m_lvl = blvl;
                m_vec = 16'(3 + 8 * best);
            end
        end
        m_ie = nie; m_ip = nip;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1; direct_wr = 1'b1;
        tick();
        wr_en = 1'b0; direct_wr = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1; tick(); reti = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        rd_addr = 8'hA8; #1;
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_ie got %h want 00", rd_data); end
        rd_addr = 8'hB8; #1;
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_ip got %h want 00", rd_data); end
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL reset_req got %b want 0", int_req); end
        n_vec++; if (int_vector !== 16'h0000) begin n_err++; $display("[TB] FAIL reset_vec got %h want 0000", int_vector); end
        n_vec++; if (dut_iacks() !== 6'b0) begin n_err++; $display("[TB] FAIL reset_iack got %b want 0", dut_iacks()); end
    endtask

    task automatic test_timer0();
        sfr_write(8'hA8, 8'h82);
        rd_addr = 8'hA8; #1;
        n_vec++; if (rd_data !== 8'h82) begin n_err++; $display("[TB] FAIL t0_ie_rd got %h want 82", rd_data); end
        timr0 = 1'b1;
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL t0_early got %b want 0", int_req); end
        tick();
        n_vec++; if (int_req !== 1'b1) begin n_err++; $display("[TB] FAIL t0_req got %b want 1", int_req); end
        n_vec++; if (int_vector !== 16'h000B) begin n_err++; $display("[TB] FAIL t0_vec got %h want 000B", int_vector); end
        tick();
        n_vec++; if (int_req !== 1'b1) begin n_err++; $display("[TB] FAIL t0_hold got %b want 1", int_req); end
        pulse_ack(); timr0 = 1'b0;
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL t0_ack_req got %b want 0", int_req); end
        n_vec++; if (dut_iacks() !== 6'b000010) begin n_err++; $display("[TB] FAIL t0_iack got %b want 000010", dut_iacks()); end
        tick();
        n_vec++; if (dut_iacks() !== 6'b0) begin n_err++; $display("[TB] FAIL t0_iack_end got %b want 0", dut_iacks()); end
    endtask

    // Entered with LO in service from the Timer 0 ack
    task automatic test_preempt();
        sfr_write(8'hB8, 8'h01);
        sfr_write(8'hA8, 8'h83);
        ext0 = 1'b1; tick();
        n_vec++; if (int_vector !== 16'h0003 || int_req !== 1'b1) begin n_err++; $display("[TB] FAIL pre_vec got %b/%h want 1/0003", int_req, int_vector); end
        pulse_ack(); ext0 = 1'b0;
        n_vec++; if (iack_ext0 !== 1'b1) begin n_err++; $display("[TB] FAIL pre_iack got %b want 1", iack_ext0); end
        tick(); ext0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL pre_held got %b want 0", int_req); end
        end
        pulse_reti();
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL pre_reti got %b want 0", int_req); end
        tick();
        n_vec++; if (int_vector !== 16'h0003 || int_req !== 1'b1) begin n_err++; $display("[TB] FAIL pre_again got %b/%h want 1/0003", int_req, int_vector); end
        pulse_ack(); ext0 = 1'b0;
        tick(); pulse_reti(); pulse_reti();
        sfr_write(8'hA8, 8'h00); sfr_write(8'hB8, 8'h00);
    endtask

    task automatic test_priority();
        sfr_write(8'hB8, 8'h04);
        sfr_write(8'hA8, 8'h85);
        ext0 = 1'b1; ext1 = 1'b1;
        tick();
        n_vec++; if (int_vector !== 16'h0013) begin n_err++; $display("[TB] FAIL prio_vec got %h want 0013", int_vector); end
        pulse_ack(); ext1 = 1'b0;
        n_vec++; if (dut_iacks() !== 6'b000100) begin n_err++; $display("[TB] FAIL prio_iack got %b want 000100", dut_iacks()); end
        tick(); tick();
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL prio_lo_held got %b want 0", int_req); end
        pulse_reti(); tick();
        n_vec++; if (int_vector !== 16'h0003 || int_req !== 1'b1) begin n_err++; $display("[TB] FAIL prio_lo got %b/%h want 1/0003", int_req, int_vector); end
        pulse_ack(); ext0 = 1'b0;
        tick(); pulse_reti();
        sfr_write(8'hA8, 8'h00); sfr_write(8'hB8, 8'h00);
    endtask

    task automatic test_abandon();
        sfr_write(8'hA8, 8'h88);
        timr1 = 1'b1; tick();
        n_vec++; if (int_vector !== 16'h001B || int_req !== 1'b1) begin n_err++; $display("[TB] FAIL ab_vec got %b/%h want 1/001B", int_req, int_vector); end
        sfr_write(8'hA8, 8'h00);
        tick();
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL ab_drop got %b want 0", int_req); end
        n_vec++; if (iack_timr1 !== 1'b0) begin n_err++; $display("[TB] FAIL ab_noiack got %b want 0", iack_timr1); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        n_vec++; if (dut_iacks() !== 6'b0) begin n_err++; $display("[TB] FAIL ab_stray_ack got %b want 0", dut_iacks()); end
        sfr_write(8'hA8, 8'h88);
        tick();
        n_vec++; if (int_req !== 1'b1) begin n_err++; $display("[TB] FAIL ab_refire got %b want 1", int_req); end
        pulse_ack(); timr1 = 1'b0;
        n_vec++; if (iack_timr1 !== 1'b1) begin n_err++; $display("[TB] FAIL ab_iack got %b want 1", iack_timr1); end
        tick();
    endtask

    // Entered with LO in service (ET1) and IE=88
    task automatic test_reti_ack();
        sfr_write(8'hB8, 8'h08);
        timr1 = 1'b1; tick();
        n_vec++; if (int_vector !== 16'h001B || int_req !== 1'b1) begin n_err++; $display("[TB] FAIL ra_vec got %b/%h want 1/001B", int_req, int_vector); end
        int_ack = 1'b1; reti = 1'b1; tick(); int_ack = 1'b0; reti = 1'b0; timr1 = 1'b0;
        n_vec++; if (iack_timr1 !== 1'b1) begin n_err++; $display("[TB] FAIL ra_iack got %b want 1", iack_timr1); end
        tick(); timr1 = 1'b1; tick(); tick();
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL ra_hi_blocks got %b want 0", int_req); end
        pulse_reti(); tick();
        n_vec++; if (int_req !== 1'b1) begin n_err++; $display("[TB] FAIL ra_after_reti got %b want 1", int_req); end
        pulse_ack(); timr1 = 1'b0;
        tick(); pulse_reti(); pulse_reti();
        sfr_write(8'hB8, 8'h00);
        timr1 = 1'b1; tick();
        n_vec++; if (int_req !== 1'b1) begin n_err++; $display("[TB] FAIL ra_idle_reti got %b want 1", int_req); end
        pulse_ack(); timr1 = 1'b0;
        tick(); pulse_reti();
        sfr_write(8'hA8, 8'h00);
    endtask

    task automatic test_reset_mid_pend();
        sfr_write(8'hA8, 8'h90);
        ser = 1'b1; tick();
        n_vec++; if (int_vector !== 16'h0023 || int_req !== 1'b1) begin n_err++; $display("[TB] FAIL rp_vec got %b/%h want 1/0023", int_req, int_vector); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_vec++; if (int_req !== 1'b0) begin n_err++; $display("[TB] FAIL rp_req got %b want 0", int_req); end
        rd_addr = 8'hA8; #1;
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("[TB] FAIL rp_ie got %h want 00", rd_data); end
        sfr_write(8'hA8, 8'h90);
        tick();
        n_vec++; if (int_req !== 1'b1) begin n_err++; $display("[TB] FAIL rp_ser got %b want 1", int_req); end
        pulse_ack();
        n_vec++; if (dut_iacks() !== 6'b0 || int_req !== 1'b0) begin n_err++; $display("[TB] FAIL rp_ser_ack got %b/%b want 0/0", dut_iacks(), int_req); end
        ser = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] addrs [3];
        logic [NS-1:0] flags;
        addrs[0] = 8'hA8; addrs[1] = 8'hB8; addrs[2] = 8'h90;
        reset = 1'b1; tick(); reset = 1'b0;
        flags = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < NS; s++) if ($urandom_range(7) == 0) flags[s] = ~flags[s];
            ext0 = flags[0]; timr0 = flags[1]; ext1 = flags[2]; timr1 = flags[3]; ser = flags[4];
`ifdef INTC_TIMR2_EN
            timr2 = flags[5];
`endif
            reset   = ($urandom_range(127) == 0);
            int_ack = ($urandom_range(3) == 0);
            reti    = ($urandom_range(15) == 0);
            wr_en   = ($urandom_range(9) == 0);
            direct_wr = wr_en ? ($urandom_range(7) != 0) : 1'b0;
            wr_addr = addrs[$urandom_range(2)];
            wr_data = 8'($urandom);
            if (wr_addr == 8'hA8 && $urandom_range(3) != 0) wr_data[7] = 1'b1;
            rd_addr = addrs[$urandom_range(2)];
            tick();
            n_vec++; if (int_req !== m_pend) begin n_err++; $display("[TB] FAIL rnd_req cyc %0d got %b want %b", cyc, int_req, m_pend); end
            if (m_pend) begin
                n_vec++; if (int_vector !== m_vec) begin n_err++; $display("[TB] FAIL rnd_vec cyc %0d got %h want %h", cyc, int_vector, m_vec); end
            end
            n_vec++; if (dut_iacks() !== m_iack) begin n_err++; $display("[TB] FAIL rnd_iack cyc %0d got %b want %b", cyc, dut_iacks(), m_iack); end
            n_vec++;
            if (rd_data !== (rd_addr == 8'hA8 ? m_ie : (rd_addr == 8'hB8 ? m_ip : 8'h00))) begin
                n_err++; $display("[TB] FAIL rnd_rd cyc %0d addr %h got %h want %h", cyc, rd_addr, rd_data,
                                  (rd_addr == 8'hA8 ? m_ie : (rd_addr == 8'hB8 ? m_ip : 8'h00)));
            end
        end
        reset = 1'b0; int_ack = 1'b0; reti = 1'b0; wr_en = 1'b0; direct_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timer0();
        test_preempt();
        test_priority();
        test_abandon();
        test_reti_ack();
        test_reset_mid_pend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
